layer_in_loader: RTL and testbench
==================================

# layer_in_loader

Streaming front-end for the combinational fully-connected `layer` datapath. It accepts one signed WIDTH-bit activation per cycle over a valid/ready stream and assembles them into the IN-entry parallel vector `x[0:IN-1]` that the layer consumes. It then holds that vector stable, flagged by `x_valid`, until the downstream capture stage acknowledges it. It sits between the previous layer's serial output and the layer's parallel input port.

## Interface
- `WIDTH`, 8, bits per activation (signed, two's complement)
- `IN`, 128, vector length; must be ≥ 2
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `s_valid`  in  1  input beat valid
- `s_ready`  out  1  loader can accept a beat (registered)
- `s_data`  in  WIDTH  activation value
- `s_last`  in  1  marks final beat of a frame
- `x`  out  WIDTH × [0:IN-1]  assembled vector; unpacked array; `x[k]` is beat k of the frame
- `x_valid`  out  1  `x` complete and stable
- `x_ack`  in  1  consumer has captured `x`; releases the buffer
- `err_len`  out  1  one-cycle pulse on a frame-length mismatch

## Operation
- A beat is accepted on a rising edge with `s_valid && s_ready`.
- Index counter `idx` is `$clog2(IN)` bits wide and resets to 0.
- **State FILL**
  - `s_ready` = 1.
  - Each accepted beat writes `x[idx] <= s_data` and increments `idx`.
  - Accepted beat with `idx == IN-1`: `idx <= 0`, go to FULL. If `s_last` = 0 on that beat, also pulse `err_len`; the vector is still delivered.
  - Accepted beat with `s_last` = 1 and `idx < IN-1` (short frame): pulse `err_len`, `idx <= 0`, stay in FILL. `x_valid` is not raised. Entries already written are overwritten by the next frame.
- **State FULL**
  - `x_valid` = 1, `s_ready` = 0, and `x` is unchanged every cycle.
  - On `x_ack` = 1: go to FILL.
- `x_ack` while `x_valid` = 0 is ignored.
- There is no wrap-around of `idx` other than the FULL transition; `idx` never exceeds IN-1.
- **Reset (async, any time, including mid-frame):**
  - state = FILL, `idx` = 0, all `x[k]` = 0.
  - `x_valid` = 0, `s_ready` = 0, `err_len` = 0.
  - Any partial frame is discarded.

## Timing
- `s_ready` and `x_valid` are registered outputs, computed from the next state.
- `s_ready` rises on the first rising edge after `rst_n` deasserts.
- Final beat accepted at edge N: `x` and `x_valid` = 1 are visible after edge N, and `s_ready` = 0 after edge N.
- `x_ack` = 1 sampled at edge M: `x_valid` = 0 and `s_ready` = 1 after edge M. The earliest next beat is accepted at edge M+1.
- Minimum frame period is IN+1 cycles with immediate ack (single buffer).
- `err_len` is high exactly the cycle after the offending beat.
- Stream throughput in FILL is 1 beat/cycle.

## Configuration
- Macro: `LAYER_IN_LOADER_DBUF_EN`.
- **Defined:** two banks A and B.
  - `x` is driven from the presented bank; beats fill the other bank.
  - `s_ready` stays 1 in FULL until the fill bank is also complete.
  - On `x_ack`: if the fill bank is complete (including completion at the same edge), banks swap and `x_valid` stays 1 with new contents the next cycle. Otherwise `x_valid` drops and the design returns to single-bank behaviour.
  - Sustained throughput is IN beats per IN cycles.
  - Both banks reset to 0.
- **Undefined:** single bank exactly as described above. No second register array is synthesized.

## Test plan
- **Reset release:** hold `rst_n` = 0 for 3 cycles → all outputs 0; after the first edge with `rst_n` = 1, `s_ready` = 1.
- **Full frame:** stream `s_data` = k−64 for k = 0..127 with `s_last` on k = 127 → `x_valid` = 1 the cycle after beat 127; `x[0]` = −64, `x[127]` = 63; `err_len` never pulses. Then `x_ack` = 1 → `x_valid` = 0 the next cycle.
- **Backpressure:** after FULL, hold `x_ack` = 0 for 20 cycles while `s_valid` = 1 with `s_data` = 8'h55 → `s_ready` = 0 throughout and `x` unchanged.
- **Short frame:** `s_last` on beat 9 → `err_len` pulse one cycle later; `x_valid` stays 0. A following correct 128-beat frame delivers normally.
- **Missing last:** 128 beats with no `s_last` → `err_len` pulse and `x_valid` = 1 in the same cycle.
- **Mid-frame reset / DBUF:** assert `rst_n` = 0 at beat 50 → `x` all 0 and `idx` restarts at 0. With `LAYER_IN_LOADER_DBUF_EN` defined: back-to-back frames with `x_ack` one cycle after each `x_valid` → `s_ready` never drops and `x_valid` stays high across the swap.

Source files
------------

// File: rtl/layer_in_loader.sv
// -----------------------------------------------------------------------------
// layer_in_loader
//
// Streaming front-end for the combinational fully-connected layer datapath.
// Signed activations arrive one per cycle on a valid/ready stream and are
// assembled into the IN-entry parallel vector x[0:IN-1]. A complete vector is
// held stable, flagged by x_valid, until the consumer acknowledges it with
// x_ack.
//
// Parameters
//   WIDTH    bits per activation (signed, two's complement)
//   IN       vector length (>= 2)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   s_valid  input beat valid
//   s_ready  loader can accept a beat (registered)
//   s_data   activation value
//   s_last   final beat of a frame
//   x        assembled vector, x[k] is beat k of the frame
//   x_valid  x complete and stable (registered)
//   x_ack    consumer has captured x; releases the buffer
//   err_len  one-cycle pulse on a frame-length mismatch
//
// Configuration
//   LAYER_IN_LOADER_DBUF_EN  when defined, two register banks are used: one is
//                            presented on x while the other fills, so frames
//                            can stream back to back. Undefined (default):
//                            a single bank.
// -----------------------------------------------------------------------------
module layer_in_loader #(
  parameter int WIDTH = 8,
  parameter int IN    = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic signed [WIDTH-1:0] x [0:IN-1],
  output logic                    x_valid,
  input  logic                    x_ack,
  output logic                    err_len
);

  localparam int IW = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(IN - 1);

  // FILL : nothing presented, collecting beats
  // FULL : a vector is presented on x
  // BOTH : (double-buffer only) presented vector plus a completed fill bank
  typedef enum logic [1:0] {FILL, FULL, BOTH} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            beat;
  logic            frame_done;
  logic            frame_short;

  assign beat        = s_valid && s_ready;
  assign frame_done  = beat && (idx == IDX_LAST);
  assign frame_short = beat && s_last && (idx != IDX_LAST);

`ifdef LAYER_IN_LOADER_DBUF_EN

  logic signed [WIDTH-1:0] bank_a [0:IN-1];
  logic signed [WIDTH-1:0] bank_b [0:IN-1];
  // fsel selects the bank being filled; the other bank is the presented one
  logic                    fsel;

  always_comb begin
    for (int k = 0; k < IN; k++) begin
      x[k] = fsel ? bank_a[k] : bank_b[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      idx     <= '0;
      fsel    <= 1'b0;
      s_ready <= 1'b0;
      x_valid <= 1'b0;
      err_len <= 1'b0;
      for (int k = 0; k < IN; k++) begin
        bank_a[k] <= '0;
        bank_b[k] <= '0;
      end
    end else begin
      // Fill-side datapath and length check are common to every state
      if (beat) begin
        if (fsel) bank_b[idx] <= s_data;
        else      bank_a[idx] <= s_data;
      end
      err_len <= frame_done ? !s_last : frame_short;
      if (frame_done || frame_short) idx <= '0;
      else if (beat)                 idx <= idx + 1'b1;

      case (state)
        FILL: begin
          s_ready <= 1'b1;
          if (frame_done) begin
            // Present the bank just completed, start filling the other one
            fsel    <= ~fsel;
            x_valid <= 1'b1;
            state   <= FULL;
          end
        end
        FULL: begin
          if (frame_done && x_ack) begin
            // Swap at the same edge: x_valid stays high with new contents
            fsel  <= ~fsel;
          end else if (frame_done) begin
            s_ready <= 1'b0;
            state   <= BOTH;
          end else if (x_ack) begin
            x_valid <= 1'b0;
            state   <= FILL;
          end
        end
        BOTH: begin
          if (x_ack) begin
            fsel    <= ~fsel;
            s_ready <= 1'b1;
            state   <= FULL;
          end
        end
        default: begin
          s_ready <= 1'b0;
          x_valid <= 1'b0;
          state   <= FILL;
        end
      endcase
    end
  end

`else

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      idx     <= '0;
      s_ready <= 1'b0;
      x_valid <= 1'b0;
      err_len <= 1'b0;
      for (int k = 0; k < IN; k++) begin
        x[k] <= '0;
      end
    end else begin
      // s_ready is 0 in FULL, so x can only change while filling
      if (beat) x[idx] <= s_data;
      err_len <= frame_done ? !s_last : frame_short;
      if (frame_done || frame_short) idx <= '0;
      else if (beat)                 idx <= idx + 1'b1;

      case (state)
        FILL: begin
          s_ready <= 1'b1;
          if (frame_done) begin
            // A missing s_last still delivers the vector, only flagged
            s_ready <= 1'b0;
            x_valid <= 1'b1;
            state   <= FULL;
          end
        end
        FULL: begin
          if (x_ack) begin
            s_ready <= 1'b1;
            x_valid <= 1'b0;
            state   <= FILL;
          end
        end
        default: begin
          s_ready <= 1'b0;
          x_valid <= 1'b0;
          state   <= FILL;
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_layer_in_loader.sv
// -----------------------------------------------------------------------------
// tb_layer_in_loader
//
// Self-checking bench for layer_in_loader (default single-bank build).
// A queue-based reference model tracks accepted beats per frame and the
// expected presented vector and control outputs.
// -----------------------------------------------------------------------------
module tb_layer_in_loader;

  localparam int WIDTH = 8;
  localparam int IN    = 128;

  logic                    clk;
  logic                    rst_n;
  logic                    s_valid;
  logic                    s_ready;
  logic signed [WIDTH-1:0] s_data;
  logic                    s_last;
  logic signed [WIDTH-1:0] x [0:IN-1];
  logic                    x_valid;
  logic                    x_ack;
  logic                    err_len;

  layer_in_loader #(.WIDTH(WIDTH), .IN(IN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .x       (x),
    .x_valid (x_valid),
    .x_ack   (x_ack),
    .err_len (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int cur[$];        // beats accepted so far in the current frame
  int m_x [IN];      // vector expected on x
  bit m_valid;
  bit m_ready;
  bit m_err;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur = {};
    for (int k = 0; k < IN; k++) m_x[k] = 0;
    m_valid = 0;
    m_ready = 0;
    m_err   = 0;
  endtask

  // One rising edge worth of behaviour, from the current input values
  task automatic model_edge();
    bit acc;
    acc   = s_valid && m_ready;
    m_err = 0;
    if (m_valid) begin
      if (x_ack) begin
        m_valid = 0;
        m_ready = 1;
      end
    end else begin
      m_ready = 1;
      if (acc) begin
        cur.push_back(int'(s_data));
        if (cur.size() == IN) begin
          for (int k = 0; k < IN; k++) m_x[k] = cur[k];
          cur     = {};
          m_valid = 1;
          m_ready = 0;
          m_err   = !s_last;
        end else if (s_last) begin
          m_err = 1;
          cur   = {};
        end
      end
    end
  endtask

  task automatic chk_ctrl(input string tag);
    chk({tag, ".s_ready"}, s_ready, m_ready);
    chk({tag, ".x_valid"}, x_valid, m_valid);
    chk({tag, ".err_len"}, err_len, m_err);
  endtask

  task automatic chk_vec(input string tag);
    for (int k = 0; k < IN; k++)
      chk($sformatf("%s.x[%0d]", tag, k), x[k], m_x[k]);
  endtask

  task automatic tick(input string tag);
    if (!rst_n) model_reset();
    else        model_edge();
    @(posedge clk);
    #1;
    chk_ctrl(tag);
  endtask

  // mode 0: data = k-64, mode 1: random. last_at < 0: no s_last.
  task automatic send_beats(input int n, input int last_at, input int mode,
                            input bit gaps, input string tag);
    for (int k = 0; k < n; k++) begin
      int  tries;
      bit  acc;
      tries = 0;
      do begin
        s_valid = gaps ? ($urandom_range(2) != 0) : 1'b1;
        s_data  = (mode == 0) ? WIDTH'(k - 64) : WIDTH'($urandom);
        s_last  = (k == last_at);
        x_ack   = gaps ? 1'($urandom_range(1)) : 1'b0;
        acc     = s_valid && m_ready;
        tick(tag);
        tries++;
      end while (!acc && tries < 100);
      if (!acc) chk({tag, ".beat_timeout"}, 0, 1);
    end
    s_valid = 0;
    s_last  = 0;
    x_ack   = 0;
  endtask

  task automatic ack(input string tag);
    x_ack = 1;
    tick(tag);
    x_ack = 0;
  endtask

  initial begin
    rst_n   = 0;
    s_valid = 0;
    s_data  = '0;
    s_last  = 0;
    x_ack   = 0;
    model_reset();

    // Reset release
    repeat (3) @(posedge clk);
    #1;
    chk_ctrl("reset");
    chk_vec("reset");
    rst_n = 1;
    tick("rel");
    chk("rel.s_ready_high", s_ready, 1);

    // Full frame, data k-64
    send_beats(IN, IN - 1, 0, 0, "full");
    chk("full.x_valid_high", x_valid, 1);
    chk("full.x0", x[0], -64);
    chk("full.x127", x[IN-1], 63);
    chk_vec("full");

    // Backpressure: beats offered, nothing accepted, x stable
    s_valid = 1;
    s_data  = 8'h55;
    for (int c = 0; c < 20; c++) begin
      tick("bp");
      chk_vec("bp");
    end
    s_valid = 0;
    ack("ack1");
    chk("ack1.x_valid_low", x_valid, 0);

    // Short frame: s_last on beat 9
    send_beats(10, 9, 1, 0, "short");
    chk("short.err", err_len, 1);
    tick("short_idle");
    send_beats(IN, IN - 1, 1, 0, "after_short");
    chk_vec("after_short");
    ack("ack2");

    // Missing s_last: vector still delivered with err_len
    send_beats(IN, -1, 1, 1, "miss");
    chk("miss.err", err_len, 1);
    chk("miss.valid", x_valid, 1);
    chk_vec("miss");
    ack("ack3");

    // Mid-frame asynchronous reset at beat 50
    send_beats(50, -1, 1, 0, "pre_rst");
    #2;
    rst_n = 0;
    model_reset();
    #1;
    chk_ctrl("midrst");
    chk_vec("midrst");
    @(posedge clk);
    #1;
    rst_n = 1;
    tick("midrst_rel");
    send_beats(IN, IN - 1, 0, 0, "post_rst");
    chk_vec("post_rst");
    ack("ack4");

    // Random frames with gaps, mixed lengths and random ack latency
    for (int f = 0; f < 6; f++) begin
      int len;
      len = ($urandom_range(2) == 0) ? int'($urandom_range(IN - 1, 1)) : IN;
      send_beats(len, len - 1, 1, 1, "rnd");
      if (m_valid) chk_vec("rnd");
      for (int c = int'($urandom_range(4)); c > 0; c--) tick("rnd_wait");
      if (m_valid) ack("rnd_ack");
    end
    tick("end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
